// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the RISC-V pipeline register blocks: flush defaults,
// the canonical NOP encoding and the kill counter width.
package riscv_pipe_pkg;

  localparam logic [31:0] RISCV_NOP         = 32'h00000013;
  localparam logic [31:0] FLUSH_VAL_DEFAULT = 32'h00000000;
  localparam int          KILL_CNT_W        = 16;
  localparam logic [KILL_CNT_W-1:0] KILL_CNT_MAX = {KILL_CNT_W{1'b1}};

  // Adds a small per-cycle increment to the kill counter, pinning at all-ones.
  function automatic logic [KILL_CNT_W-1:0] kill_cnt_sat_add(
    input logic [KILL_CNT_W-1:0] cnt,
    input int unsigned           inc
  );
    int unsigned sum;
    sum = 32'(cnt) + inc;
    if (sum > 32'(KILL_CNT_MAX))
      return KILL_CNT_MAX;
    return sum[KILL_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_flush_stage.sv
// One flushable, stallable pipeline stage: a data register plus its valid bit.
module pipe_flush_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  // Invalid slots always carry FLUSH_VAL, so a bubble never leaks stale data.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      data_reg  <= FLUSH_VAL;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      data_reg  <= v ? d : FLUSH_VAL;
      valid_reg <= v;
    end
  end

  assign q       = data_reg;
  assign q_valid = valid_reg;

endmodule

// File: rtl/pipe_flush_reg.sv
// Chain of DEPTH flushable register stages with global stall and per-stage kill.
// Define PIPE_FLUSH_REG_STATS_EN to add the kill_cnt statistics port.
module pipe_flush_reg
  import riscv_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(FLUSH_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [DEPTH-1:0] flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic [DEPTH-1:0] stage_valid
`ifdef PIPE_FLUSH_REG_STATS_EN
  ,
  output logic [KILL_CNT_W-1:0] kill_cnt
`endif
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_cfg
    $error("pipe_flush_reg: DEPTH and WIDTH must both be at least 1");
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] chain_data [DEPTH];
  logic [DEPTH-1:0] chain_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign chain_data[gi]  = din;
        assign chain_valid[gi] = in_valid;
      end else begin : g_link
        assign chain_data[gi]  = stage_data[gi-1];
        assign chain_valid[gi] = stage_valid[gi-1];
      end

      pipe_flush_stage #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush[gi]),
        .stall   (stall),
        .d       (chain_data[gi]),
        .v       (chain_valid[gi]),
        .q       (stage_data[gi]),
        .q_valid (stage_valid[gi])
      );
    end
  endgenerate

  assign dout      = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

`ifdef PIPE_FLUSH_REG_STATS_EN
  logic [DEPTH-1:0]      kill_vec;
  logic [KILL_CNT_W-1:0] kill_cnt_reg;
  logic [KILL_CNT_W-1:0] kill_cnt_next;

  // A kill counts only if the item the stage would have held after this edge
  // is live: its own item when stalled, otherwise the incoming one.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign kill_vec[gi] = flush[gi] & (stall ? stage_valid[gi] : chain_valid[gi]);
    end
  endgenerate

  always_comb begin
    kill_cnt_next = kill_cnt_sat_add(kill_cnt_reg, $countones(kill_vec));
  end

  always_ff @(posedge clk) begin
    if (reset)
      kill_cnt_reg <= '0;
    else
      kill_cnt_reg <= kill_cnt_next;
  end

  assign kill_cnt = kill_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_flush_reg.sv
// Scoreboard bench for pipe_flush_reg (WIDTH=32, DEPTH=2, FLUSH_VAL=RISC-V NOP).
module tb_pipe_flush_reg;
  import riscv_pipe_pkg::*;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] FV    = RISCV_NOP;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic [DEPTH-1:0] flush;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic [DEPTH-1:0] stage_valid;
`ifdef PIPE_FLUSH_REG_STATS_EN
  logic [15:0]      kill_cnt;
`endif

  pipe_flush_reg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .FLUSH_VAL (FV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .din         (din),
    .dout        (dout),
    .out_valid   (out_valid),
    .stage_valid (stage_valid)
`ifdef PIPE_FLUSH_REG_STATS_EN
    ,
    .kill_cnt    (kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      dout;
    logic             ov;
    logic [DEPTH-1:0] sv;
    logic [15:0]      kc;
  } exp_t;

  exp_t             sb_q [$];
  logic [31:0]      m_d [DEPTH];
  logic [DEPTH-1:0] m_v;
  logic [15:0]      m_kc;
  int               n_checks = 0;
  int               n_errors = 0;
  bit               verbose  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic s,
                      input logic [DEPTH-1:0] f, input logic iv, input logic [31:0] d);
    exp_t             e;
    logic [31:0]      nd [DEPTH];
    logic [DEPTH-1:0] nv;
    int               kills;
    reset = r; stall = s; flush = f; in_valid = iv; din = d;
    kills = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic        iv_i;
      logic [31:0] id_i;
      iv_i = (i == 0) ? iv : m_v[i-1];
      id_i = (i == 0) ? (iv ? d : FV) : m_d[i-1];
      if (r) begin
        nv[i] = 1'b0; nd[i] = FV;
      end else if (f[i]) begin
        if (s ? m_v[i] : iv_i) kills++;
        nv[i] = 1'b0; nd[i] = FV;
      end else if (s) begin
        nv[i] = m_v[i]; nd[i] = m_d[i];
      end else begin
        nv[i] = iv_i; nd[i] = id_i;
      end
    end
    for (int i = 0; i < DEPTH; i++) m_d[i] = nd[i];
    m_v = nv;
    if (r) m_kc = 16'h0;
    else if (32'(m_kc) + kills > 32'hFFFF) m_kc = 16'hFFFF;
    else m_kc = m_kc + 16'(kills);
    e.dout = m_d[DEPTH-1]; e.ov = m_v[DEPTH-1]; e.sv = m_v; e.kc = m_kc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".dout"}, dout, e.dout);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    check({tag, ".stage_valid"}, 32'(stage_valid), 32'(e.sv));
`ifdef PIPE_FLUSH_REG_STATS_EN
    check({tag, ".kill_cnt"}, 32'(kill_cnt), 32'(e.kc));
`endif
    if (verbose)
      $display("%-10s rst=%b stall=%b flush=%b iv=%b din=%h -> dout=%h ov=%b sv=%b",
               tag, r, s, f, iv, d, dout, out_valid, stage_valid);
  endtask

  task automatic fill_ab(input logic [31:0] a, input logic [31:0] b);
    step("fill_b", 1'b0, 1'b0, 2'b00, 1'b1, b);
    step("fill_a", 1'b0, 1'b0, 2'b00, 1'b1, a);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_d[i] = 32'hx;
    m_v  = 'x;
    m_kc = 'x;
    reset = 1'b1; stall = 1'b0; flush = '0; in_valid = 1'b0; din = '0;

    step("reset0", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    step("reset1", 1'b1, 1'b1, 2'b11, 1'b1, 32'h55);
    check("rst_dout", dout, FV);
    check("rst_ov", 32'(out_valid), 32'h0);

    // Stream 1,2,3: each appears two edges after being sampled.
    step("s_1", 1'b0, 1'b0, 2'b00, 1'b1, 32'd1);
    check("lat_e1_ov", 32'(out_valid), 32'h0);
    step("s_2", 1'b0, 1'b0, 2'b00, 1'b1, 32'd2);
    check("lat_e2", dout, 32'd1);
    step("s_3", 1'b0, 1'b0, 2'b00, 1'b1, 32'd3);
    check("lat_e3", dout, 32'd2);
    step("s_bub", 1'b0, 1'b0, 2'b00, 1'b0, 32'hBAD);
    check("lat_e4", dout, 32'd3);
    step("s_bub", 1'b0, 1'b0, 2'b00, 1'b0, 32'hBAD);
    check("bubble_dout", dout, FV);

    // Stage 0 = A, stage 1 = B; hold three cycles, then A emerges.
    fill_ab(32'hAAAA_0001, 32'hBBBB_0002);
    for (int k = 0; k < 3; k++) begin
      step("stall", 1'b0, 1'b1, 2'b00, 1'b1, 32'hC0DE_0000 + k);
      check("stall_hold_b", dout, 32'hBBBB_0002);
    end
    step("unstall", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    check("unstall_a", dout, 32'hAAAA_0001);

    fill_ab(32'hAAAA_0011, 32'hBBBB_0012);
    step("fl01_st", 1'b0, 1'b1, 2'b01, 1'b1, 32'h1234);
    check("fl01_keep_b", dout, 32'hBBBB_0012);
    check("fl01_sv", 32'(stage_valid), 32'h2);
    step("fl01_adv", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);

    fill_ab(32'hAAAA_0021, 32'hBBBB_0022);
    step("fl11_st", 1'b0, 1'b1, 2'b11, 1'b1, 32'h5678);
    check("fl11_dout", dout, FV);

    // Reset mid-stream drops everything; new item surfaces two edges later.
    fill_ab(32'hAAAA_0031, 32'hBBBB_0032);
    step("rst_st", 1'b1, 1'b1, 2'b00, 1'b1, 32'h9999);
    step("post_rst1", 1'b0, 1'b0, 2'b00, 1'b1, 32'h7777);
    step("post_rst2", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    check("post_rst_item", dout, 32'h7777);

    // Constrained-random traffic.
    for (int k = 0; k < 300; k++) begin
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30),
           (($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00),
           ($urandom_range(0, 99) < 70), $urandom);
    end

`ifdef PIPE_FLUSH_REG_STATS_EN
    step("kc_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    fill_ab(32'hAAAA_0041, 32'hBBBB_0042);
    step("kc_fl11", 1'b0, 1'b0, 2'b11, 1'b1, 32'h1);
    check("kc_plus2", 32'(kill_cnt), 32'h2);
    step("kc_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    verbose = 1'b0;
    for (int k = 0; k < 32767; k++) begin
      step("kc_fill", 1'b0, 1'b0, 2'b00, 1'b1, 32'(k));
      step("kc_kill", 1'b0, 1'b0, 2'b11, 1'b1, 32'(k));
    end
    verbose = 1'b1;
    check("kc_fffe", 32'(kill_cnt), 32'hFFFE);
    fill_ab(32'hAAAA_0051, 32'hBBBB_0052);
    step("kc_sat", 1'b0, 1'b0, 2'b11, 1'b1, 32'h2);
    check("kc_ffff", 32'(kill_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_flush_reg.md
PIPE_FLUSH_REG -- requirements
Module: pipe_flush_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per stage in bits.
REQ-002 SHALL have parameter DEPTH, default 2, number of chained register stages.
REQ-003 SHALL have parameter FLUSH_VAL, default 0 (WIDTH bits), data value loaded on reset, flush or bubble.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold all non-flushed stages.
REQ-007 SHALL have port flush  input  DEPTH  per-stage kill; bit i targets stage i.
REQ-008 SHALL have port in_valid  input  1  din carries a live item.
REQ-009 SHALL have port din  input  WIDTH  data entering stage 0.
REQ-010 SHALL have port dout  output  WIDTH  data of stage DEPTH-1.
REQ-011 SHALL have port out_valid  output  1  valid bit of stage DEPTH-1.
REQ-012 SHALL have port stage_valid  output  DEPTH  valid bit of every stage, bit i = stage i.

Function
REQ-013 SHALL hold per stage i one WIDTH-bit data register and one valid bit; stage 0 is fed from din/in_valid, stage i from stage i-1.
REQ-014 SHALL, per stage per cycle, apply priority reset > flush[i] > stall > advance.
REQ-015 SHALL, on flush[i], load stage i with valid=0 and data=FLUSH_VAL, discarding both its held and its incoming item, regardless of stall.
REQ-016 SHALL, on stall without flush[i], hold stage i data and valid unchanged.
REQ-017 SHALL, on advance, load stage i with stage i-1 (or din/in_valid for stage 0).
REQ-018 SHALL load FLUSH_VAL rather than din into stage 0 data when advancing with in_valid=0 (bubble).
REQ-019 SHALL give latency of exactly DEPTH rising edges from din sampled to dout, with no stall or flush.
REQ-020 SHALL drive dout, out_valid and stage_valid directly from registers; no combinational path from any input to any output.
REQ-021 SHALL, with stall=1 and flush[k]=1, leave stage k+1 holding its own item, not pull the bubble from stage k.
REQ-022 SHALL, with DEPTH=1, behave as a single flushable register with stall.
REQ-023 SHALL fail elaboration when DEPTH < 1 or WIDTH < 1.

Reset
REQ-024 SHALL, on a rising edge with reset=1, set every stage valid=0 and data=FLUSH_VAL, overriding stall and flush.
REQ-025 SHALL hence reset dout=FLUSH_VAL, out_valid=0, stage_valid=0, and, when compiled in, kill_cnt=0.
REQ-026 SHALL, on reset mid-operation, drop all in-flight items; the first item accepted after reset deasserts emerges DEPTH edges later.

Configuration
REQ-027 SHALL, with macro PIPE_FLUSH_REG_STATS_EN defined, add output port kill_cnt (16 bits) counting valid items destroyed by flush.
REQ-028 SHALL add to kill_cnt per cycle the number of stages i with flush[i]=1 whose item would otherwise have been valid after this edge, saturating at 16'hFFFF.
REQ-029 SHALL, without PIPE_FLUSH_REG_STATS_EN, omit kill_cnt port and counter logic entirely; all other behaviour identical.

Structure
REQ-030 SHALL take FLUSH_VAL defaults and the RISC-V NOP constant (32'h00000013) from shared package riscv_pipe_pkg; the package also holds the kill_cnt width constant (16).
REQ-031 SHALL build stages from one sub-module pipe_flush_stage (one data+valid register, inputs reset/flush/stall/d/v), instantiated DEPTH times via generate.

Verification
REQ-032 SHALL cover: WIDTH=32, DEPTH=2, stream din=1,2,3 with in_valid=1 -> dout=1,2,3 on edges 2,3,4, out_valid=1 on those edges.
REQ-033 SHALL cover: stall=1 for 3 cycles with stages holding A,B -> dout=B and stage_valid=2'b11 held 3 cycles, then A emerges next edge.
REQ-034 SHALL cover: flush=2'b01 with stall=1, stages A,B -> stage 0 valid=0 data=FLUSH_VAL, stage 1 keeps B.
REQ-035 SHALL cover: flush=2'b11 and stall=1 same cycle -> stage_valid=2'b00, dout=FLUSH_VAL next edge.
REQ-036 SHALL cover: reset=1 with stall=1, flush=0, pipe full -> all outputs at reset values next edge, kill_cnt=0.
REQ-037 SHALL cover (STATS_EN): flush=2'b11 on full pipe -> kill_cnt +2; from 16'hFFFE further kill of 2 -> kill_cnt=16'hFFFF.
